// File: rtl/ps2_digit_entry.sv
// PS/2 keyboard front end for the card-validation datapath: conditions the raw
// lines, receives 11-bit frames and turns digit / Enter / Esc presses into strobes.
module ps2_digit_entry #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       start_pulse,
    output logic       clear_pulse,
    output logic       frame_error,
    output logic [7:0] last_code,
    output logic [1:0] rx_state_dbg,
    output logic [1:0] dec_state_dbg
);
    // Handshake: every output strobe is a one-cycle pulse with no ready/backpressure;
    // the consumer must take digit in the cycle digit_valid is high.
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_NORM, D_BRK, D_EXT, D_EXTBRK} dec_state_t;

    localparam int FC_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_filt;
    logic [FC_W-1:0] filt_cnt;
    logic            sample_evt;

    rx_state_t       rx_state, rx_next;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_hit, byte_accept, byte_reject, byte_ready;

    dec_state_t      dec_state, dec_next;
    logic [7:0]      held, held_next;
    logic [3:0]      digit_next;
    logic            emit_digit, emit_start, emit_clear;
    logic [4:0]      dig_dec;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1 <= 1'b1; clk_s2 <= 1'b1;
            dat_s1 <= 1'b1; dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK; clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT; dat_s2 <= dat_s1;
        end
    end

    // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FC_LAST) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign sample_evt  = clk_filt & ~clk_s2 & (filt_cnt == FC_LAST);
    assign timeout_hit = (rx_state != RX_IDLE) && (to_cnt == TO_MAX);

    always_comb begin
        rx_next     = rx_state;
        byte_accept = 1'b0;
        byte_reject = 1'b0;
        if (timeout_hit) begin
            rx_next     = RX_IDLE;
            byte_reject = 1'b1;
        end else if (sample_evt) begin
            case (rx_state)
                RX_IDLE:   if (!dat_s2) rx_next = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) rx_next = RX_PARITY;
                RX_PARITY: rx_next = RX_STOP;
                RX_STOP: begin
                    rx_next = RX_IDLE;
                    if (dat_s2 && (^{shift_reg, parity_bit})) byte_accept = 1'b1;
                    else                                      byte_reject = 1'b1;
                end
                default:   rx_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            to_cnt      <= '0;
            byte_ready  <= 1'b0;
            frame_error <= 1'b0;
            last_code   <= '0;
        end else begin
            byte_ready  <= byte_accept;
            frame_error <= byte_reject;
            if (byte_accept) last_code <= shift_reg;
            if (sample_evt) begin
                to_cnt <= '0;
                case (rx_state)
                    RX_IDLE: bit_cnt <= '0;
                    RX_DATA: begin
                        shift_reg <= {dat_s2, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= dat_s2;
                    default: ;
                endcase
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    // {is_digit, value} for number-row and keypad make codes.
    function automatic logic [4:0] decode_digit(input logic [7:0] code);
        case (code)
            8'h45, 8'h70: decode_digit = {1'b1, 4'd0};
            8'h16, 8'h69: decode_digit = {1'b1, 4'd1};
            8'h1E, 8'h72: decode_digit = {1'b1, 4'd2};
            8'h26, 8'h7A: decode_digit = {1'b1, 4'd3};
            8'h25, 8'h6B: decode_digit = {1'b1, 4'd4};
            8'h2E, 8'h73: decode_digit = {1'b1, 4'd5};
            8'h36, 8'h74: decode_digit = {1'b1, 4'd6};
            8'h3D, 8'h6C: decode_digit = {1'b1, 4'd7};
            8'h3E, 8'h75: decode_digit = {1'b1, 4'd8};
            8'h46, 8'h7D: decode_digit = {1'b1, 4'd9};
            default:      decode_digit = 5'd0;
        endcase
    endfunction

    assign dig_dec = decode_digit(last_code);

    // last_code carries the accepted byte in the cycle byte_ready is high.
    always_comb begin
        dec_next   = dec_state;
        held_next  = held;
        digit_next = digit;
        emit_digit = 1'b0;
        emit_start = 1'b0;
        emit_clear = 1'b0;
        if (byte_ready) begin
            case (dec_state)
                D_NORM: begin
                    if (last_code == 8'hF0)      dec_next = D_BRK;
                    else if (last_code == 8'hE0) dec_next = D_EXT;
                    else begin
                        held_next = last_code;
                        if (last_code != held) begin
                            if (dig_dec[4]) begin
                                emit_digit = 1'b1;
                                digit_next = dig_dec[3:0];
                            end else if (last_code == 8'h5A) begin
                                emit_start = 1'b1;
                            end else if (last_code == 8'h76) begin
                                emit_clear = 1'b1;
                            end
                        end
                    end
                end
                D_BRK: begin
                    dec_next = D_NORM;
                    if (last_code == held) held_next = 8'h00;
                end
                D_EXT: begin
                    if (last_code == 8'hF0) dec_next = D_EXTBRK;
                    else begin
                        dec_next = D_NORM;
                        if (last_code == 8'h5A) emit_start = 1'b1;
                    end
                end
                D_EXTBRK: begin
                    dec_next  = D_NORM;
                    held_next = 8'h00;
                end
                default: dec_next = D_NORM;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dec_state   <= D_NORM;
            held        <= 8'h00;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            start_pulse <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            dec_state   <= dec_next;
            held        <= held_next;
            digit       <= digit_next;
            digit_valid <= emit_digit;
            start_pulse <= emit_start;
            clear_pulse <= emit_clear;
        end
    end

    assign rx_state_dbg  = rx_state;
    assign dec_state_dbg = dec_state;
endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed bench for ps2_digit_entry: PS/2 frames are bit-banged, expected strobes
// are queued by the driver and matched by an independent negedge monitor.
module tb_ps2_digit_entry;
    localparam int HALF = 20;
    localparam int GAP  = 40;
    localparam int W    = 44;
    localparam logic [3:0] K_NONE = 4'd0, K_DIG = 4'd1, K_START = 4'd2,
                           K_CLEAR = 4'd3, K_FE = 4'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_dat;
    logic [3:0] digit;
    logic       digit_valid, start_pulse, clear_pulse, frame_error;
    logic [7:0] last_code;
    logic [1:0] rx_state_dbg, dec_state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];

    ps2_digit_entry #(.FILTER_LEN(2), .TIMEOUT_CYCLES(200)) dut (
        .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .digit(digit), .digit_valid(digit_valid), .start_pulse(start_pulse),
        .clear_pulse(clear_pulse), .frame_error(frame_error), .last_code(last_code),
        .rx_state_dbg(rx_state_dbg), .dec_state_dbg(dec_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int at, input logic [3:0] kind, input logic [7:0] val);
        logic [31:0] at_v;
        at_v = at;
        exp_q.push_back({at_v, kind, val});
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Stop-bit falling edge is driven at cycle fc: error strobe at fc+4, decoded strobe at fc+5.
    task automatic send_byte(input logic [7:0] data, input logic bad_par,
                             input logic [3:0] kind, input logic [7:0] val);
        int fc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit((~^data) ^ bad_par);
        ps2_dat = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        fc = cyc;
        if (kind != K_NONE) expect_ev(fc + ((kind == K_FE) ? 4 : 5), kind, val);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send_partial(input logic [7:0] data, input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset === 1'b0 && (digit_valid || start_pulse || clear_pulse || frame_error)) begin
            logic [3:0]   kind;
            logic [7:0]   val;
            logic [W-1:0] e;
            int           n;
            n = int'(digit_valid) + int'(start_pulse) + int'(clear_pulse) + int'(frame_error);
            if (n > 1) begin
                tests++;
                fails++;
                $display("FAIL onehot: %0d strobes together at cycle %0d", n, cyc);
            end
            kind = frame_error ? K_FE : digit_valid ? K_DIG : start_pulse ? K_START : K_CLEAR;
            val  = digit_valid ? {4'd0, digit} : 8'd0;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: kind %0d val %0d at cycle %0d, none queued",
                         kind, val, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e[11:8] !== kind || e[7:0] !== val ||
                    (e[43:12] != 0 && e[43:12] != 32'(cyc))) begin
                    fails++;
                    $display("FAIL strobe: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                             kind, val, cyc, e[11:8], e[7:0], e[43:12]);
                end
            end
        end
    end

    // stimulus
    initial begin
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        reset   = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(1);
        check("rst_digit", 32'(digit), 0);
        check("rst_digit_valid", 32'(digit_valid), 0);
        check("rst_start", 32'(start_pulse), 0);
        check("rst_clear", 32'(clear_pulse), 0);
        check("rst_frame_error", 32'(frame_error), 0);
        check("rst_last_code", 32'(last_code), 0);
        check("rst_rx_state", 32'(rx_state_dbg), 0);
        check("rst_dec_state", 32'(dec_state_dbg), 0);

        send_byte(8'h3D, 1'b0, K_DIG, 8'd7);
        send_byte(8'hF0, 1'b0, K_NONE, 8'd0);
        send_byte(8'h3D, 1'b0, K_NONE, 8'd0);

        // reset in the middle of a frame
        send_partial(8'h16, 3);
        reset = 1'b1;
        wait_cyc(5);
        reset   = 1'b0;
        ps2_dat = 1'b1;
        check("midrst_digit", 32'(digit), 0);
        check("midrst_last_code", 32'(last_code), 0);
        check("midrst_rx_state", 32'(rx_state_dbg), 0);
        check("midrst_strobes", 32'({digit_valid, start_pulse, clear_pulse, frame_error}), 0);
        wait_cyc(HALF);

        send_byte(8'h16, 1'b0, K_DIG, 8'd1);
        send_byte(8'hF0, 1'b0, K_NONE, 8'd0);
        send_byte(8'h16, 1'b0, K_NONE, 8'd0);
        check("last_code_16", 32'(last_code), 32'h16);

        // typematic repeats, release, then press again
        send_byte(8'h3E, 1'b0, K_DIG, 8'd8);
        send_byte(8'h3E, 1'b0, K_NONE, 8'd0);
        send_byte(8'h3E, 1'b0, K_NONE, 8'd0);
        send_byte(8'hF0, 1'b0, K_NONE, 8'd0);
        send_byte(8'h3E, 1'b0, K_NONE, 8'd0);
        send_byte(8'h3E, 1'b0, K_DIG, 8'd8);

        send_byte(8'h45, 1'b1, K_FE, 8'd0);
        check("last_code_after_parity_err", 32'(last_code), 32'h3E);
        send_byte(8'h45, 1'b0, K_DIG, 8'd0);

        send_byte(8'hE0, 1'b0, K_NONE, 8'd0);
        send_byte(8'h5A, 1'b0, K_START, 8'd0);
        send_byte(8'h76, 1'b0, K_CLEAR, 8'd0);
        send_byte(8'h7D, 1'b0, K_DIG, 8'd9);
        send_byte(8'h1C, 1'b0, K_NONE, 8'd0);
        check("last_code_1C", 32'(last_code), 32'h1C);
        check("digit_held", 32'(digit), 9);

        // partial frame aborted by the timeout
        send_partial(8'h26, 4);
        expect_ev(0, K_FE, 8'd0);
        ps2_dat = 1'b1;
        wait_cyc(250);
        check("timeout_rx_idle", 32'(rx_state_dbg), 0);
        check("timeout_last_code", 32'(last_code), 32'h1C);
        send_byte(8'h26, 1'b0, K_DIG, 8'd3);

        wait_cyc(50);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_digit_entry.md
# ps2_digit_entry

Upstream stage of the card-validation datapath. Receives raw PS/2 keyboard frames and decodes number-row and keypad digit make codes into one-cycle digit strobes for the Luhn checker. Also decodes Enter (start check) and Escape (clear entry). Replaces the one-hot SW/KEY0 digit entry path with a keyboard path; downstream consumes exactly one strobe per key press.

## Interface
- FILTER_LEN, 8: consecutive identical CLOCK_50 samples required before the filtered PS/2 clock changes level.
- TIMEOUT_CYCLES, 50000: CLOCK_50 cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- PS2_CLK  in  1  raw keyboard clock, asynchronous, idle high.
- PS2_DAT  in  1  raw keyboard data, asynchronous, idle high.
- digit  out  4  last decoded digit value 0-9; held between strobes.
- digit_valid  out  1  one-cycle strobe; digit is valid in the same cycle.
- start_pulse  out  1  one-cycle strobe on Enter press.
- clear_pulse  out  1  one-cycle strobe on Escape press.
- frame_error  out  1  one-cycle strobe on parity, stop-bit or timeout failure.
- last_code  out  8  last correctly received byte (debug/HEX display).

## Operation
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer. Filtered clock (reset value 1) toggles only after FILTER_LEN equal synchronized samples. A falling edge of the filtered clock is the bit-sample event; PS2_DAT is sampled from its synchronizer on that cycle.
- Receiver FSM RX_IDLE, RX_DATA, RX_PARITY, RX_STOP:
  - RX_IDLE: sample 0 -> RX_DATA with bit counter 0. Sample 1 is ignored; state stays RX_IDLE.
  - RX_DATA: shift 8 bits LSB first. After bit 7 -> RX_PARITY.
  - RX_PARITY: store bit -> RX_STOP.
  - RX_STOP: if stop = 1 and data+parity has odd parity, the byte is accepted (internal byte_ready) and last_code is updated. Otherwise frame_error pulses and the byte is discarded. Both cases -> RX_IDLE.
  - Timeout counter clears on every sample event and saturates. If it reaches TIMEOUT_CYCLES in any state other than RX_IDLE: -> RX_IDLE, frame_error pulses, partial byte discarded.
- Decoder FSM D_NORM, D_BRK, D_EXT, D_EXTBRK; advances only on accepted bytes:
  - D_NORM:
    - F0 -> D_BRK; E0 -> D_EXT.
    - Digit make code whose code != held: emit digit, set held = code.
    - Number-row codes: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
    - Keypad codes: 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
    - 5A (Enter) and 76 (Esc) -> start_pulse / clear_pulse, with the same held check.
    - Other codes: set held = code, no strobe.
  - D_BRK: any byte -> D_NORM, no strobe. If byte == held, clear held to 00.
  - D_EXT: 5A -> start_pulse (keypad Enter), -> D_NORM. F0 -> D_EXTBRK. Other -> D_NORM, no strobe.
  - D_EXTBRK: any byte -> D_NORM, clears held; no strobe.
- Typematic repeats of a held key produce no additional strobes.
- A frame_error does not change decoder state or held.
- At most one of digit_valid, start_pulse, clear_pulse is asserted in any cycle.

## Timing
- Reset values:
  - digit = 0, digit_valid = 0, start_pulse = 0, clear_pulse = 0, frame_error = 0, last_code = 00.
  - Receiver in RX_IDLE, decoder in D_NORM, held = 00, filter outputs 1, timeout counter 0.
- Synchronous reset mid-frame abandons the frame with no strobe and no frame_error.
- Synchronizer + filter delay: 2 + FILTER_LEN cycles from a raw PS2_CLK edge to the sample event.
- byte_ready is registered 1 cycle after the stop-bit sample event.
- digit_valid, start_pulse and clear_pulse are registered 1 cycle after byte_ready, i.e. 2 cycles after the stop-bit sample event.
- frame_error asserts 1 cycle after the failing stop-bit sample event, or 1 cycle after the timeout is reached.
- last_code updates in the same cycle as byte_ready.
- All strobes are exactly 1 CLOCK_50 cycle wide. Back-to-back bytes are separated by at least 11 PS/2 bit periods, so no buffering is required.

## Test plan
Bench sets FILTER_LEN = 2 and TIMEOUT_CYCLES = 200, and drives PS/2 bits at 20 CLOCK_50 cycles per half-period.
- Reset asserted 5 cycles mid-frame -> all outputs 0 immediately after. The next valid frame 16 yields digit_valid with digit = 1.
- Frame 16 (parity bit 0), then F0, 16 -> exactly one digit_valid, digit = 1, 2 cycles after the stop sample; last_code ends at 16; no other strobes.
- Bytes 3E, 3E, 3E, F0, 3E -> exactly one digit_valid with digit = 8. A following 3E yields a second strobe.
- Frame 45 with parity bit inverted -> one frame_error pulse, no digit_valid, last_code unchanged. A following correct 45 -> digit_valid with digit = 0.
- Sequence E0, 5A -> start_pulse once. Byte 76 -> clear_pulse once. Byte 7D -> digit 9. Byte 1C (letter A) -> no strobe.
- Start bit plus 4 data bits, then idle 250 cycles -> frame_error once, receiver returns to RX_IDLE. A following frame 26 -> digit 3.
